trace_frame_sync: RTL and testbench

- Sits directly downstream of the trace-port pin capture and upstream of the frame/packet consumer in orbtrace.
- Accepts 1/2/4-bit trace samples and detects the TPIU full sync word 0x7FFFFFFF at arbitrary bit alignment.
- Strips full and half syncs, assembles aligned 16-byte TPIU frames, and hands them downstream over a valid/ready handshake.
- Reports sync status, overflow and loss-of-sync to the LED/status logic.

---
 rtl/trace_pkg.sv | 13 +
 rtl/trace_frame_sync_if.sv | 8 +
 rtl/trace_sync_window.sv | 27 ++
 rtl/trace_frame_sync.sv | 119 +++++++++++
 tb/tb_trace_frame_sync.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/trace_pkg.sv
// trace_pkg: shared constants, width encoding and state type for TPIU frame sync
package trace_pkg;
    localparam logic [31:0] TPIU_FULL_SYNC = 32'h7FFFFFFF;
    localparam logic [15:0] TPIU_HALF_SYNC = 16'h7FFF;
    localparam int FRAME_BITS = 128;
    localparam logic [1:0] W_1BIT = 2'd0;
    localparam logic [1:0] W_2BIT = 2'd1;
    localparam logic [1:0] W_4BIT = 2'd2;
    typedef enum logic {UNSYNC, SYNCED} state_t;
    function automatic logic [2:0] nbits(input logic [1:0] w);
        return w == W_1BIT ? 3'd1 : w == W_2BIT ? 3'd2 : 3'd4;
    endfunction
endpackage

// File: rtl/trace_frame_sync_if.sv
// trace_frame_sync_if: valid/ready frame stream towards the packet consumer
interface trace_frame_sync_if;
    logic [127:0] frame;
    logic frame_valid;
    logic frame_ready;
    modport master(output frame, frame_valid, input frame_ready);
    modport slave(input frame, frame_valid, output frame_ready);
endinterface

// File: rtl/trace_sync_window.sv
// trace_sync_window: 32-bit sliding bit window with full-sync comparator
module trace_sync_window
    import trace_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] width,
    input  logic [3:0] din,
    input  logic       din_valid,
    input  logic       clr,
    output logic       match
);
    logic [31:0] win;
    logic [31:0] win_nxt;
    // new bits enter at the MSB so the oldest bit of the window sits at bit 0
    always_comb begin
        win_nxt = width == W_1BIT ? {din[0], win[31:1]} :
                  width == W_2BIT ? {din[1:0], win[31:2]} : {din, win[31:4]};
        match = din_valid && !clr && win_nxt == TPIU_FULL_SYNC;
    end
    // window register, cleared on width change
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) win <= '0;
        else if (clr) win <= '0;
        else if (din_valid) win <= win_nxt;
    end
endmodule

// File: rtl/trace_frame_sync.sv
// trace_frame_sync: locks onto TPIU sync, strips syncs and emits aligned 16-byte frames
module trace_frame_sync
    import trace_pkg::*;
#(
    parameter int TO_W = 24,
    parameter logic [TO_W-1:0] SYNC_TIMEOUT = 24'd1048575
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] width,
    input  logic [3:0] din,
    input  logic       din_valid,
    trace_frame_sync_if.master fo,
    output logic       synced,
    output logic       frame_ovf,
    output logic       sync_lost
);
    state_t state, state_nxt;
    logic [6:0] bit_cnt, bc_nxt;
    logic [127:0] acc, acc_nxt, acc_w, frame_q, frame_nxt;
    logic [TO_W-1:0] to_cnt, to_nxt, to_inc;
    logic fv, fv_nxt, ovf_nxt, lost_nxt, done, width_chg, match;
    logic [1:0] width_q;
    logic [2:0] n;
    logic [3:0] mask;
    logic [7:0] post;

    trace_sync_window u_win (
        .clk(clk), .rst(rst), .width(width), .din(din),
        .din_valid(din_valid), .clr(width_chg), .match(match)
    );

    assign fo.frame = frame_q;
    assign fo.frame_valid = fv;
    assign synced = state == SYNCED;

    // next-state: sync hunting, frame assembly, timeout and output handshake
    always_comb begin
        n = nbits(width);
        mask = n == 3'd1 ? 4'h1 : n == 3'd2 ? 4'h3 : 4'hF;
        width_chg = width != width_q;
        post = {1'b0, bit_cnt} + {5'd0, n};
        acc_w = (acc & ~({124'd0, mask} << bit_cnt)) | ({124'd0, din & mask} << bit_cnt);
        to_inc = to_cnt + TO_W'(1);
        state_nxt = state;
        bc_nxt = bit_cnt;
        acc_nxt = acc;
        to_nxt = to_cnt;
        frame_nxt = frame_q;
        fv_nxt = fv & ~fo.frame_ready;
        ovf_nxt = 1'b0;
        lost_nxt = 1'b0;
        done = 1'b0;
        if (width_chg) begin
            state_nxt = UNSYNC;
            bc_nxt = '0;
            to_nxt = '0;
        end else if (din_valid) begin
            if (state == UNSYNC) begin
                if (match) begin
                    state_nxt = SYNCED;
                    bc_nxt = '0;
                    to_nxt = '0;
                end
            end else begin
                acc_nxt = acc_w;
                bc_nxt = post[6:0];
                to_nxt = to_inc;
                done = post == 8'd128;
                if (post == 8'd16 && acc_w[15:0] == TPIU_HALF_SYNC) bc_nxt = '0;
                // a re-sync on a 32-bit boundary restarts the frame; it is not an error
                if (post[4:0] == 5'd0 && match) begin
                    bc_nxt = '0;
                    to_nxt = '0;
                    done = 1'b0;
                end else if (to_inc == SYNC_TIMEOUT) begin
                    // a frame finishing on the timeout sample is still delivered
                    state_nxt = UNSYNC;
                    bc_nxt = '0;
                    to_nxt = '0;
                    lost_nxt = 1'b1;
                end
            end
        end
        if (done) begin
            if (!fv || fo.frame_ready) begin
                frame_nxt = acc_w;
                fv_nxt = 1'b1;
            end else begin
                ovf_nxt = 1'b1;
            end
        end
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= UNSYNC;
            bit_cnt <= '0;
            acc <= '0;
            to_cnt <= '0;
            frame_q <= '0;
            fv <= 1'b0;
            frame_ovf <= 1'b0;
            sync_lost <= 1'b0;
            width_q <= '0;
        end else begin
            state <= state_nxt;
            bit_cnt <= bc_nxt;
            acc <= acc_nxt;
            to_cnt <= to_nxt;
            frame_q <= frame_nxt;
            fv <= fv_nxt;
            frame_ovf <= ovf_nxt;
            sync_lost <= lost_nxt;
            width_q <= width;
        end
    end
endmodule

// File: tb/tb_trace_frame_sync.sv
// tb_trace_frame_sync: directed checks of sync, framing, handshake, timeout and reset
module tb_trace_frame_sync;
    logic clk = 1'b0;
    logic rst;
    logic [1:0] width;
    logic [3:0] din;
    logic din_valid;
    logic ready;
    logic synced1, ovf1, lost1, synced2, ovf2, lost2;
    int checks = 0;
    int failures = 0;
    int ovf_n = 0;
    int lost_n = 0;
    int base;

    trace_frame_sync_if f1();
    trace_frame_sync_if f2();
    assign f1.frame_ready = ready;
    assign f2.frame_ready = ready;

    trace_frame_sync dut1 (
        .clk(clk), .rst(rst), .width(width), .din(din), .din_valid(din_valid),
        .fo(f1), .synced(synced1), .frame_ovf(ovf1), .sync_lost(lost1)
    );

    trace_frame_sync #(.SYNC_TIMEOUT(24'd64)) dut2 (
        .clk(clk), .rst(rst), .width(width), .din(din), .din_valid(din_valid),
        .fo(f2), .synced(synced2), .frame_ovf(ovf2), .sync_lost(lost2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        ovf_n <= ovf_n + int'(ovf1);
        lost_n <= lost_n + int'(lost2);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d);
        din = d;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        if (width == 2'd0) for (int i = 0; i < 8; i++) send({3'b0, b[i]});
        else if (width == 2'd1) for (int i = 0; i < 4; i++) send({2'b0, b[2*i+:2]});
        else for (int i = 0; i < 2; i++) send(b[4*i+:4]);
    endtask

    task automatic send_sync();
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'h7F);
    endtask

    task automatic send_frame(input logic [7:0] b);
        for (int i = 0; i < 16; i++) send_byte(b);
    endtask

    task automatic drain();
        ready = 1'b1;
        idle(1);
        ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        width = 2'd0;
        din = '0;
        din_valid = 1'b0;
        ready = 1'b0;
        idle(3);
        rst = 1'b1;
        idle(1);
        chk("rst_fv", f1.frame_valid, 0);
        chk("rst_frame", f1.frame, 0);
        chk("rst_synced", synced1, 0);
        chk("rst_ovf", ovf1, 0);
        chk("rst_lost", lost1, 0);

        // 1-bit port: sync, then bytes 0x00..0x0F
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'hFF);
        for (int i = 0; i < 7; i++) send(4'h1);
        chk("w1_presync", synced1, 0);
        send(4'h0);
        chk("w1_synced", synced1, 1);
        for (int i = 0; i < 15; i++) send_byte(8'(i));
        for (int i = 0; i < 7; i++) send({3'b0, i < 4});
        chk("w1_fv_early", f1.frame_valid, 0);
        send(4'h0);
        chk("w1_fv", f1.frame_valid, 1);
        chk("w1_frame", f1.frame, 128'h0F0E0D0C0B0A09080706050403020100);
        drain();
        chk("w1_drained", f1.frame_valid, 0);

        // 4-bit port with a half sync ahead of the frame
        width = 2'd2;
        idle(2);
        chk("w4_unsync", synced1, 0);
        base = ovf_n;
        send_sync();
        chk("w4_synced", synced1, 1);
        send_byte(8'hFF);
        send_byte(8'h7F);
        send_frame(8'hA5);
        chk("w4_fv", f1.frame_valid, 1);
        chk("w4_frame", f1.frame, {16{8'hA5}});
        chk("w4_no_ovf", ovf_n - base, 0);
        drain();

        // back-pressure: second frame dropped with one ovf pulse
        base = ovf_n;
        send_frame(8'h11);
        chk("bp_fv", f1.frame_valid, 1);
        send_frame(8'h22);
        chk("bp_ovf_pulse", ovf1, 1);
        chk("bp_held", f1.frame, {16{8'h11}});
        idle(1);
        chk("bp_ovf_end", ovf1, 0);
        chk("bp_ovf_once", ovf_n - base, 1);
        drain();
        chk("bp_fv_drop", f1.frame_valid, 0);
        chk("bp_frame_kept", f1.frame, {16{8'h11}});

        // completion in the same cycle as consumption
        base = ovf_n;
        send_frame(8'h33);
        for (int i = 0; i < 15; i++) send_byte(8'h44);
        send(4'h4);
        ready = 1'b1;
        send(4'h4);
        ready = 1'b0;
        chk("same_fv", f1.frame_valid, 1);
        chk("same_frame", f1.frame, {16{8'h44}});
        chk("same_no_ovf", ovf_n - base, 0);
        drain();

        // 2-bit port: partial frame discarded by a re-sync on a 32-bit boundary
        width = 2'd1;
        idle(2);
        send_sync();
        chk("w2_synced", synced1, 1);
        for (int i = 0; i < 4; i++) send_byte(8'h3C);
        send_sync();
        chk("w2_no_frame", f1.frame_valid, 0);
        chk("w2_still_synced", synced1, 1);
        send_frame(8'h5A);
        chk("w2_fv", f1.frame_valid, 1);
        chk("w2_frame", f1.frame, {16{8'h5A}});
        drain();

        // timeout of 64 samples on the second instance, then mid-frame reset
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        width = 2'd2;
        idle(2);
        base = lost_n;
        send_sync();
        chk("to_synced", synced2, 1);
        ready = 1'b1;
        for (int i = 0; i < 63; i++) send(4'h6);
        chk("to_not_yet", synced2, 1);
        send(4'h6);
        ready = 1'b0;
        chk("to_lost_pulse", lost2, 1);
        chk("to_unsynced", synced2, 0);
        chk("to_fv_kept", f2.frame_valid, 1);
        chk("to_frame", f2.frame, {16{8'h66}});
        idle(1);
        chk("to_lost_end", lost2, 0);
        chk("to_lost_once", lost_n - base, 1);
        chk("to_dut1_synced", synced1, 1);
        send(4'h6);
        send(4'h6);
        send(4'h6);
        chk("mid_fv1_pre", f1.frame_valid, 1);
        #3;
        rst = 1'b0;
        #1;
        chk("async_fv2", f2.frame_valid, 0);
        chk("async_fv1", f1.frame_valid, 0);
        chk("async_synced1", synced1, 0);
        chk("async_frame1", f1.frame, 0);
        idle(1);
        rst = 1'b1;
        idle(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
